pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter.sv | 101 ++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready handshake on both sides.
// One registered stage per shift-amount bit; stage k shifts by 2^k when s[k]=1.
// Modes: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
// Optional feature macro: BARREL_ROTATE_EN. When undefined, mode 11 is a logical left.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         D,
  input  logic [$clog2(WIDTH)-1:0] s,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         Q
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Per-stage pipeline contents: valid, partial data, shift amount, mode.
  logic             valid_q [SW];
  logic             valid_d [SW];
  logic [WIDTH-1:0] data_q  [SW];
  logic [WIDTH-1:0] data_d  [SW];
  logic [SW-1:0]    s_q     [SW];
  logic [SW-1:0]    s_d     [SW];
  logic [1:0]       mode_q  [SW];
  logic [1:0]       mode_d  [SW];

  logic advance;

  // One fixed-distance shift step; arithmetic right keeps the MSB, which
  // always equals the accepted operand's sign bit because earlier stages preserve it.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input int unsigned      amt,
                                                  input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    r = d << amt;
    case (m)
      MODE_LSL: r = d << amt;
      MODE_LSR: r = d >> amt;
      MODE_ASR: r = WIDTH'($signed(d) >>> amt);
`ifdef BARREL_ROTATE_EN
      MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
`else
      MODE_ROL: r = d << amt;
`endif
      default:  r = d << amt;
    endcase
    return r;
  endfunction

  // Whole pipeline moves only when the output slot is empty or being drained.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[SW-1];
  assign Q         = data_q[SW-1];

  // Next-state of every stage: stage 0 from the ports, stage k from stage k-1.
  always_comb begin
    valid_d[0] = in_valid;
    s_d[0]     = s;
    mode_d[0]  = mode;
    data_d[0]  = s[0] ? shift_step(D, 1, mode) : D;
    for (int k = 1; k < SW; k++) begin
      valid_d[k] = valid_q[k-1];
      s_d[k]     = s_q[k-1];
      mode_d[k]  = mode_q[k-1];
      data_d[k]  = ((s_q[k-1] & (SW'(1) << k)) != '0)
                   ? shift_step(data_q[k-1], 32'(1) << k, mode_q[k-1])
                   : data_q[k-1];
    end
  end

  // Stage registers: cleared asynchronously, loaded together on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        s_q[k]     <= '0;
        mode_q[k]  <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < SW; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        s_q[k]     <= s_d[k];
        mode_q[k]  <= mode_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH=16 (latency 4).
// Build with BARREL_ROTATE_EN defined to exercise the rotate variant.
module tb_pipelined_barrel_shifter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] D;
  logic [3:0]  s;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;

  int pass_cnt;
  int chk_cnt;

  pipelined_barrel_shifter #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .s         (s),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run-time guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; D = '0; s = '0; mode = '0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || Q !== 16'h0000)
      $display("FAIL reset_before_clk: out_valid=%b Q=%h required 0/0000", out_valid, Q);
    else pass_cnt++;
    tick(); tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (Q !== 16'h0000) $display("FAIL reset_q: got %h required 0000", Q);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
    rst = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
    tick();
  endtask

  // One operand through an otherwise empty pipeline; checks latency and result.
  task automatic run_single(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] m,
                            input logic [15:0] exp, input string name);
    int n;
    in_valid = 1'b1; D = d; s = sh; mode = m; out_ready = 1'b1;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (n != 4) $display("FAIL %s_latency: got %0d cycles required 4", name, n);
    else pass_cnt++;
    chk_cnt++;
    if (Q !== exp) $display("FAIL %s_q: got %h required %h", name, Q, exp);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_modes();
    run_single(16'hCCCC, 4'd5, 2'b00, 16'h9980, "lsl");
    run_single(16'hCCCC, 4'd5, 2'b01, 16'h0666, "lsr");
    run_single(16'hCCCC, 4'd5, 2'b10, 16'hFE66, "asr");
`ifdef BARREL_ROTATE_EN
    run_single(16'hCCCC, 4'd5, 2'b11, 16'h9999, "rol");
`else
    run_single(16'hCCCC, 4'd5, 2'b11, 16'h9980, "mode11");
`endif
    run_single(16'hA5A5, 4'd0, 2'b10, 16'hA5A5, "s0_asr");
    run_single(16'h8001, 4'd15, 2'b01, 16'h0001, "lsr15");
    run_single(16'h8001, 4'd15, 2'b10, 16'hFFFF, "asr15");
  endtask

  // Back-to-back sweep: 16 operands on consecutive cycles, results one per cycle.
  task automatic test_back_to_back();
    int got;
    logic [15:0] exp;
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        in_valid = 1'b1; D = 16'h8001; s = 4'(i); mode = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 3 && i <= 18) begin
        exp = 16'h8001 << (i - 3);
        chk_cnt++;
        if (out_valid !== 1'b1 || Q !== exp)
          $display("FAIL sweep_%0d: out_valid=%b Q=%h required 1/%h", i - 3, out_valid, Q, exp);
        else pass_cnt++;
        if (out_valid === 1'b1) got++;
      end else if (i < 3) begin
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL sweep_early_%0d: out_valid=%b required 0", i, out_valid);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (got != 16) $display("FAIL sweep_count: got %0d required 16", got);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] op_d [5] = '{16'h1234, 16'h1234, 16'hF000, 16'h8000, 16'h0001};
    logic [3:0]  op_s [5] = '{4'd4, 4'd4, 4'd8, 4'd15, 4'd15};
    logic [1:0]  op_m [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    logic [15:0] op_e [5] = '{16'h2340, 16'h0123, 16'hFFF0, 16'hFFFF, 16'h8000};
    int  sent;
    int  got;
    logic acc;
    sent = 0;
    got  = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (sent < 5) begin
        in_valid = 1'b1; D = op_d[sent]; s = op_s[sent]; mode = op_m[sent];
      end else in_valid = 1'b0;
      if (c >= 4) begin
        chk_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || Q !== op_e[0])
          $display("FAIL stall_hold_c%0d: in_ready=%b out_valid=%b Q=%h required 0/1/%h",
                   c, in_ready, out_valid, Q, op_e[0]);
        else pass_cnt++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    chk_cnt++;
    if (sent != 4) $display("FAIL stall_accepted: got %0d required 4", sent);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (sent < 5) begin
        in_valid = 1'b1; D = op_d[sent]; s = op_s[sent]; mode = op_m[sent];
      end else in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        chk_cnt++;
        if (Q !== op_e[got]) $display("FAIL stall_drain_%0d: got %h required %h", got, Q, op_e[got]);
        else pass_cnt++;
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (got != 5) $display("FAIL stall_drain_count: got %0d required 5", got);
    else pass_cnt++;
    tick(); tick(); tick(); tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL stall_no_dup: out_valid=%b required 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; D = 16'hFFFF; s = 4'(i + 1); mode = 2'b01;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || Q !== 16'h0000)
      $display("FAIL midrst_immediate: out_valid=%b Q=%h required 0/0000", out_valid, Q);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    chk_cnt++;
    if (stale != 0) $display("FAIL midrst_stale: got %0d stale cycles required 0", stale);
    else pass_cnt++;
    run_single(16'h00FF, 4'd3, 2'b01, 16'h001F, "after_rst");
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
